// File: rtl/vga_display_ctrl.sv
// VGA timing generator with renderer-latency-matched colour/sync outputs.
// The counters issue request coordinates (sx, sy); a PIX_LAT-deep delay line
// carries the matching position, active and sync flags so that the external
// renderer's pixel and the built-in test patterns leave the output register
// together with their own sync levels, PIX_LAT+1 cycles after the request.
module vga_display_ctrl #(
  parameter int   H_ACTIVE  = 640,
  parameter int   H_FP      = 16,
  parameter int   H_SYNC    = 96,
  parameter int   H_BP      = 48,
  parameter int   V_ACTIVE  = 480,
  parameter int   V_FP      = 10,
  parameter int   V_SYNC    = 2,
  parameter int   V_BP      = 33,
  parameter logic HSYNC_POL = 1'b0,
  parameter logic VSYNC_POL = 1'b0,
  parameter int   COLOR_W   = 4,
  parameter int   PIX_LAT   = 1,
  parameter int   CNT_W     = 10
) (
  input  logic                   clk_25,
  input  logic                   rst,
  input  logic [1:0]             mode,
  input  logic [3*COLOR_W-1:0]   solid_rgb,
  input  logic [3*COLOR_W-1:0]   pix_rgb,
  output logic [CNT_W-1:0]       sx,
  output logic [CNT_W-1:0]       sy,
  output logic                   req_active,
  output logic [COLOR_W-1:0]     vga_r,
  output logic [COLOR_W-1:0]     vga_g,
  output logic [COLOR_W-1:0]     vga_b,
  output logic                   hsync,
  output logic                   vsync,
  output logic                   frame_start,
  output logic [7:0]             frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_BEG  = H_ACTIVE + H_FP;
  localparam int HS_END  = HS_BEG + H_SYNC;
  localparam int VS_BEG  = V_ACTIVE + V_FP;
  localparam int VS_END  = VS_BEG + V_SYNC;
  localparam int BAR_W   = H_ACTIVE / 8;
  localparam int RGB_W   = 3 * COLOR_W;
  localparam logic [CNT_W-1:0]   H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0]   V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [COLOR_W-1:0] C_ONES = '1;
  localparam logic [COLOR_W-1:0] C_ZERO = '0;

  // Elaboration guards: illegal parameter sets stop the build.
  if (COLOR_W < 1 || COLOR_W > 8) begin : g_bad_color_w
    $error("vga_display_ctrl: COLOR_W must be 1..8");
  end
  if (PIX_LAT < 1 || PIX_LAT > 4) begin : g_bad_pix_lat
    $error("vga_display_ctrl: PIX_LAT must be 1..4");
  end
  if (CNT_W < 6 || CNT_W > 30 || (1 << CNT_W) < H_TOTAL || (1 << CNT_W) < V_TOTAL) begin : g_bad_cnt_w
    $error("vga_display_ctrl: CNT_W too small for H_TOTAL/V_TOTAL or the checkerboard bit");
  end
  if (H_ACTIVE < 8 || V_ACTIVE < 1) begin : g_bad_active
    $error("vga_display_ctrl: active area too small for 8 colour bars");
  end

  // Colour bar index: which of the 8 equal-width bars column h falls in.
  function automatic logic [2:0] bar_idx(input logic [CNT_W-1:0] h);
    int k;
    k = int'(h) / BAR_W;
    if (k > 7) k = 7;
    return k[2:0];
  endfunction

  // Colour for one pixel according to the mode latched for its frame.
  function automatic logic [RGB_W-1:0] pattern_rgb(input logic [1:0]       m,
                                                   input logic [CNT_W-1:0] h,
                                                   input logic [CNT_W-1:0] v,
                                                   input logic [RGB_W-1:0] pix,
                                                   input logic [RGB_W-1:0] solid);
    logic [2:0]       k;
    logic [RGB_W-1:0] rgb;
    k = bar_idx(h);
    case (m)
      2'd0:    rgb = pix;
      2'd1:    rgb = {k[2] ? C_ONES : C_ZERO, k[1] ? C_ONES : C_ZERO, k[0] ? C_ONES : C_ZERO};
      2'd2:    rgb = (h[5] ^ v[5]) ? {3{C_ONES}} : {3{C_ZERO}};
      default: rgb = solid;
    endcase
    return rgb;
  endfunction

  logic [CNT_W-1:0] sx_q, sx_d, sy_q, sy_d;
  logic             act_c, hs_c, vs_c, first_c;
  logic [1:0]       mode_c, mode_q;

  // Next position: sx wraps every line, sy advances on each sx wrap.
  always_comb begin
    sx_d = sx_q + CNT_W'(1);
    sy_d = sy_q;
    if (sx_q == H_LAST) begin
      sx_d = '0;
      sy_d = (sy_q == V_LAST) ? '0 : sy_q + CNT_W'(1);
    end
  end

  // Position counters.
  always_ff @(posedge clk_25) begin
    if (rst) begin
      sx_q <= '0;
      sy_q <= '0;
    end else begin
      sx_q <= sx_d;
      sy_q <= sy_d;
    end
  end

  // Flags describing the current request position; the mode seen at (0,0)
  // applies to the whole frame that starts there.
  always_comb begin
    act_c   = (int'(sx_q) < H_ACTIVE) && (int'(sy_q) < V_ACTIVE);
    hs_c    = (int'(sx_q) >= HS_BEG) && (int'(sx_q) < HS_END);
    vs_c    = (int'(sy_q) >= VS_BEG) && (int'(sy_q) < VS_END);
    first_c = (sx_q == '0) && (sy_q == '0);
    mode_c  = first_c ? mode : mode_q;
  end

  // Effective mode: captured at the frame origin and continuously during reset.
  always_ff @(posedge clk_25) begin
    if (rst || first_c) mode_q <= mode;
  end

  assign sx         = sx_q;
  assign sy         = sy_q;
  assign req_active = act_c;

  // ---- delay line: stage i holds the request issued i+1 cycles earlier ----
  logic [CNT_W-1:0]   dl_h_q    [PIX_LAT];
  logic [CNT_W-1:0]   dl_v_q    [PIX_LAT];
  logic [1:0]         dl_mode_q [PIX_LAT];
  logic [PIX_LAT-1:0] dl_act_q, dl_hs_q, dl_vs_q, dl_first_q;

  // Control flags of the delay line; cleared so no pre-reset entry survives.
  always_ff @(posedge clk_25) begin
    if (rst) begin
      dl_act_q   <= '0;
      dl_hs_q    <= '0;
      dl_vs_q    <= '0;
      dl_first_q <= '0;
    end else begin
      dl_act_q[0]   <= act_c;
      dl_hs_q[0]    <= hs_c;
      dl_vs_q[0]    <= vs_c;
      dl_first_q[0] <= first_c;
      for (int i = 1; i < PIX_LAT; i++) begin
        dl_act_q[i]   <= dl_act_q[i-1];
        dl_hs_q[i]    <= dl_hs_q[i-1];
        dl_vs_q[i]    <= dl_vs_q[i-1];
        dl_first_q[i] <= dl_first_q[i-1];
      end
    end
  end

  // Position and mode data of the delay line; meaningless while the flags are clear.
  always_ff @(posedge clk_25) begin
    dl_h_q[0]    <= sx_q;
    dl_v_q[0]    <= sy_q;
    dl_mode_q[0] <= mode_c;
    for (int i = 1; i < PIX_LAT; i++) begin
      dl_h_q[i]    <= dl_h_q[i-1];
      dl_v_q[i]    <= dl_v_q[i-1];
      dl_mode_q[i] <= dl_mode_q[i-1];
    end
  end

  // ---- output stage: joins the delayed request with the renderer pixel ----
  logic [CNT_W-1:0]   h_l, v_l;
  logic [1:0]         mode_l;
  logic               act_l, hs_l, vs_l, first_l;
  logic [RGB_W-1:0]   rgb_l;
  logic [COLOR_W-1:0] vga_r_q, vga_g_q, vga_b_q;
  logic               hsync_q, vsync_q, fs_q;
  logic [7:0]         fc_q;

  assign h_l     = dl_h_q[PIX_LAT-1];
  assign v_l     = dl_v_q[PIX_LAT-1];
  assign mode_l  = dl_mode_q[PIX_LAT-1];
  assign act_l   = dl_act_q[PIX_LAT-1];
  assign hs_l    = dl_hs_q[PIX_LAT-1];
  assign vs_l    = dl_vs_q[PIX_LAT-1];
  assign first_l = dl_first_q[PIX_LAT-1];

  // Colour of the pixel leaving the delay line this cycle.
  always_comb begin
    rgb_l = pattern_rgb(mode_l, h_l, v_l, pix_rgb, solid_rgb);
  end

  // Registered outputs: blanked colour, sync polarity, frame pulse and count.
  always_ff @(posedge clk_25) begin
    if (rst) begin
      vga_r_q <= '0;
      vga_g_q <= '0;
      vga_b_q <= '0;
      hsync_q <= ~HSYNC_POL;
      vsync_q <= ~VSYNC_POL;
      fs_q    <= 1'b0;
      fc_q    <= 8'd0;
    end else begin
      {vga_r_q, vga_g_q, vga_b_q} <= act_l ? rgb_l : '0;
      hsync_q <= hs_l ? HSYNC_POL : ~HSYNC_POL;
      vsync_q <= vs_l ? VSYNC_POL : ~VSYNC_POL;
      fs_q    <= first_l;
      if (first_l) fc_q <= fc_q + 8'd1;
    end
  end

  assign vga_r       = vga_r_q;
  assign vga_g       = vga_g_q;
  assign vga_b       = vga_b_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign frame_start = fs_q;
  assign frame_cnt   = fc_q;

endmodule

// File: tb/tb_vga_display_ctrl.sv
// Bench for vga_display_ctrl: two instances on a reduced 80x55 timing,
// PIX_LAT=1 with low syncs and PIX_LAT=4 with high syncs, fed by one
// stimulus stream and checked every cycle against a position-based model.
module tb_vga_display_ctrl;
  localparam int HA = 64, HFP = 4, HSW = 8, HBP = 4, HT = 80;
  localparam int VA = 48, VFP = 2, VSW = 2, VBP = 3, VT = 55;
  localparam int FT = HT * VT;
  localparam int CW = 7;
  localparam int MAXC = 50000;

  logic clk_25 = 1'b0;
  always #20 clk_25 = ~clk_25;

  logic        rst = 1'b1;
  logic [1:0]  mode = 2'd0;
  logic [11:0] solid_rgb = 12'hF00;
  logic [11:0] pix_a = 12'h000, pix_b = 12'h000;

  logic [CW-1:0] sx_a, sy_a, sx_b, sy_b;
  logic          ra_a, ra_b, hs_a, hs_b, vs_a, vs_b, fs_a, fs_b;
  logic [3:0]    r_a, g_a, b_a, r_b, g_b, b_b;
  logic [7:0]    fc_a, fc_b;

  vga_display_ctrl #(.H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
                     .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
                     .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .COLOR_W(4), .PIX_LAT(1), .CNT_W(CW))
  u_a (.clk_25(clk_25), .rst(rst), .mode(mode), .solid_rgb(solid_rgb), .pix_rgb(pix_a),
       .sx(sx_a), .sy(sy_a), .req_active(ra_a), .vga_r(r_a), .vga_g(g_a), .vga_b(b_a),
       .hsync(hs_a), .vsync(vs_a), .frame_start(fs_a), .frame_cnt(fc_a));

  vga_display_ctrl #(.H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
                     .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
                     .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .COLOR_W(4), .PIX_LAT(4), .CNT_W(CW))
  u_b (.clk_25(clk_25), .rst(rst), .mode(mode), .solid_rgb(solid_rgb), .pix_rgb(pix_b),
       .sx(sx_b), .sy(sy_b), .req_active(ra_b), .vga_r(r_b), .vga_g(g_b), .vga_b(b_b),
       .hsync(hs_b), .vsync(vs_b), .frame_start(fs_b), .frame_cnt(fc_b));

  // Per-cycle history of stimulus and the model's counter position.
  bit          rst_h   [MAXC];
  logic [11:0] solid_h [MAXC];
  int          hh      [MAXC];
  int          vh      [MAXC];
  logic [1:0]  em_h    [MAXC];
  bit          dir_h   [MAXC];

  int n = -1;
  int n_cmp = 0, n_bad = 0;
  bit done = 1'b0;

  int exp_fc [2] = '{0, 0};
  bit armed [2] = '{1'b1, 1'b1};
  bit fm_valid [2] = '{1'b0, 1'b0};
  int fm_cyc [2] = '{0, 0};
  int fm_hs [2] = '{0, 0};
  int fm_vs [2] = '{0, 0};
  int fm_checks [2] = '{0, 0};
  int pin_hits [2] = '{0, 0};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %0h, want %0h", nm, n, act, exp);
    end
  endtask

  // Renderer: each pixel carries its own coordinates.
  function automatic logic [11:0] fpix(input int h, input int v);
    logic [3:0] a, b;
    a = h[3:0];
    b = v[3:0];
    return {a, b, 4'hF};
  endfunction

  // Expected active-area colour from the mode rules.
  function automatic logic [11:0] exp_color(input int m, input int h, input int v, input logic [11:0] solid);
    int k;
    logic [3:0] r, g, b;
    case (m)
      0: return fpix(h, v);
      1: begin
        k = h / (HA / 8);
        if (k > 7) k = 7;
        r = ((k / 4) % 2 == 1) ? 4'hF : 4'h0;
        g = ((k / 2) % 2 == 1) ? 4'hF : 4'h0;
        b = (k % 2 == 1) ? 4'hF : 4'h0;
        return {r, g, b};
      end
      2: return (((h / 32) + (v / 32)) % 2 == 1) ? 12'hFFF : 12'h000;
      default: return solid;
    endcase
  endfunction

  // Hand-computed output pixels for the directed frames.
  function automatic bit pin_rgb(input int m, input int h, input int v, output logic [11:0] rgb);
    rgb = 12'h000;
    if (m == 1 && v == 0) begin
      if (h == 0)  begin rgb = 12'h000; return 1'b1; end
      if (h == 8)  begin rgb = 12'h00F; return 1'b1; end
      if (h == 16) begin rgb = 12'h0F0; return 1'b1; end
      if (h == 24) begin rgb = 12'h0FF; return 1'b1; end
      if (h == 32) begin rgb = 12'hF00; return 1'b1; end
      if (h == 63) begin rgb = 12'hFFF; return 1'b1; end
      if (h == 64) begin rgb = 12'h000; return 1'b1; end
      if (h == 79) begin rgb = 12'h000; return 1'b1; end
    end
    if (m == 2) begin
      if (h == 32 && v == 0)  begin rgb = 12'hFFF; return 1'b1; end
      if (h == 0  && v == 0)  begin rgb = 12'h000; return 1'b1; end
      if (h == 32 && v == 32) begin rgb = 12'h000; return 1'b1; end
      if (h == 0  && v == 40) begin rgb = 12'hFFF; return 1'b1; end
    end
    if (m == 0 && h == 5  && v == 3)  begin rgb = 12'h53F; return 1'b1; end
    if (m == 0 && h == 47 && v == 13) begin rgb = 12'hFDF; return 1'b1; end
    if (m == 3 && h == 10 && v == 10) begin rgb = 12'hF00; return 1'b1; end
    return 1'b0;
  endfunction

  task automatic cmp_dut(input int id, input int L, input logic ph, input logic pv,
                         input logic [CW-1:0] sxv, input logic [CW-1:0] syv, input logic rav,
                         input logic [11:0] rgb, input logic hsv, input logic vsv,
                         input logic fsv, input logic [7:0] fcv);
    int m;
    bit clean, act;
    logic [11:0] e_rgb, prgb;
    logic e_hs, e_vs, e_fs;
    string tag;
    tag = (id == 0) ? "A" : "B";
    chk({tag, ".coord"}, {sxv, syv, rav},
        {CW'(hh[n]), CW'(vh[n]), (hh[n] < HA && vh[n] < VA)});
    m = n - L - 1;
    e_rgb = 12'h000; e_hs = ~ph; e_vs = ~pv; e_fs = 1'b0;
    if (rst_h[n-1]) begin
      exp_fc[id] = 0;
      chk({tag, ".rst"}, {rgb, hsv, vsv, fsv, fcv}, {12'h000, ~ph, ~pv, 1'b0, 8'h00});
      fm_valid[id] = 1'b0;
      armed[id] = 1'b1;
    end else begin
      clean = (m >= 0);
      for (int k = (m < 0 ? 0 : m); k <= n - 2; k++) if (rst_h[k]) clean = 1'b0;
      if (clean) begin
        act = (hh[m] < HA) && (vh[m] < VA);
        if (act) e_rgb = exp_color(int'(em_h[m]), hh[m], vh[m], solid_h[n-1]);
        if (hh[m] >= HA + HFP && hh[m] < HA + HFP + HSW) e_hs = ph;
        if (vh[m] >= VA + VFP && vh[m] < VA + VFP + VSW) e_vs = pv;
        e_fs = (hh[m] == 0 && vh[m] == 0);
        if (e_fs) exp_fc[id] = (exp_fc[id] + 1) % 256;
        if (dir_h[m] && pin_rgb(int'(em_h[m]), hh[m], vh[m], prgb)) begin
          chk({tag, ".pin"}, rgb, prgb);
          pin_hits[id]++;
        end
      end
    end
    chk({tag, ".out"}, {rgb, hsv, vsv, fsv, fcv}, {e_rgb, e_hs, e_vs, e_fs, 8'(exp_fc[id])});
    if (fsv === 1'b1) begin
      if (armed[id]) begin
        chk({tag, ".fcnt_first"}, fcv, 8'd1);
        armed[id] = 1'b0;
      end
      if (fm_valid[id]) begin
        chk({tag, ".frame_len"}, fm_cyc[id], 4400);   // 80 * 55
        chk({tag, ".hs_cycles"}, fm_hs[id], 440);     // 8 per line * 55 lines
        chk({tag, ".vs_cycles"}, fm_vs[id], 160);     // 2 lines * 80
        fm_checks[id]++;
      end
      fm_valid[id] = 1'b1;
      fm_cyc[id] = 0; fm_hs[id] = 0; fm_vs[id] = 0;
    end
    fm_cyc[id]++;
    if (hsv === ph) fm_hs[id]++;
    if (vsv === pv) fm_vs[id]++;
  endtask

  // Compare process: mid-cycle, both instances against the model.
  initial begin
    forever begin
      @(negedge clk_25);
      if (!done && n >= 1) begin
        cmp_dut(0, 1, 1'b0, 1'b0, sx_a, sy_a, ra_a, {r_a, g_a, b_a}, hs_a, vs_a, fs_a, fc_a);
        cmp_dut(1, 4, 1'b1, 1'b1, sx_b, sy_b, ra_b, {r_b, g_b, b_b}, hs_b, vs_b, fs_b, fc_b);
      end
    end
  end

  // Stimulus: directed frames (mode 0, 1, 2, 0->3 switch, mid-frame reset),
  // then random mode/colour changes and rare reset pulses.
  initial begin
    int pos, f, h, v;
    logic [1:0] em_cur;
    pos = 0; f = 0; em_cur = 2'd0;
    for (int c = 0; c < MAXC - 1; c++) begin
      @(posedge clk_25);
      #1;
      n++;
      if (n == 0 || rst_h[n-1]) pos = 0;
      else pos = (pos + 1) % FT;
      h = pos % HT;
      v = pos / HT;
      hh[n] = h;
      vh[n] = v;
      if (f < 6) begin
        rst = (n < 5) || (f == 5 && h == 30 && v == 10);
        if (f == 1 && h == 20 && v == 30) mode = 2'd1;
        if (f == 2 && pos == 1234) mode = 2'd2;
        if (f == 3 && h == 50 && v == 5) mode = 2'd0;
        if (f == 4 && h == 10 && v == 20) mode = 2'd3;
      end else begin
        if ($urandom_range(0, 499) == 0) mode = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 699) == 0) solid_rgb = 12'($urandom);
        rst = ($urandom_range(0, 8999) == 0);
      end
      if (pos == 0 && !rst) f++;
      if (rst || pos == 0) em_cur = mode;
      rst_h[n] = rst;
      solid_h[n] = solid_rgb;
      em_h[n] = em_cur;
      dir_h[n] = (f < 6);
      pix_a = (n >= 1) ? fpix(hh[n-1], vh[n-1]) : 12'h000;
      pix_b = (n >= 4) ? fpix(hh[n-4], vh[n-4]) : 12'h000;
      if (f >= 10 && pos >= 300) break;
    end
    done = 1'b1;
    @(negedge clk_25);
    chk("A.pins_seen", pin_hits[0] >= 15, 1'b1);
    chk("B.pins_seen", pin_hits[1] >= 15, 1'b1);
    chk("A.frames_seen", fm_checks[0] >= 5, 1'b1);
    chk("B.frames_seen", fm_checks[1] >= 5, 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
